uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter with a one-entry holding
// register, optional even/odd parity bit and one or two stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic             bit_end;
    logic             accept;
    logic             load;

    assign bit_end = (cnt_q == CNT_LAST);
    // The holding register only takes a byte while empty, so an accept can
    // never coincide with the holding-to-shifter transfer.
    assign accept  = i_valid && !hold_full_q;

    // Next-state, counters, holding/shift register and registered line level.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        par_d       = par_q;
        done_d      = 1'b0;
        load        = 1'b0;
        tx_d        = 1'b1;
        cnt_d       = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Move the held byte into the shifter; parity is fixed at this point
        // so later i_data activity cannot disturb the frame.
        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY_ODD != 0);
            hold_full_d = 1'b0;
            bit_idx_d   = 3'd0;
            stop_idx_d  = 1'b0;
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = i_data;
        end

        // Line level follows the state being entered so o_tx is registered
        // yet aligned with the state register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // Control state with asynchronous reset: aborts any frame and drops the held byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    // Data payload registers; their contents are qualified by the control state.
    always_ff @(posedge i_clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign o_ready = !hold_full_q;
    assign o_busy  = (state_q != IDLE);
    assign o_tx    = tx_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx instances (no parity, even parity, odd parity,
// two stop bits) share one stimulus stream and are compared every cycle
// against a frame-level model, plus literal expectations for key frames.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam logic [3:0] PEN_V = 4'b0110;
    localparam logic [3:0] POD_V = 4'b0100;
    localparam logic [3:0] SB2_V = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] tx_w, ready_w, busy_w, done_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            uart_tx #(
                .CLKS_PER_BIT(CPB),
                .PARITY_EN   (PEN_V[g] ? 1 : 0),
                .PARITY_ODD  (POD_V[g] ? 1 : 0),
                .STOP_BITS   (SB2_V[g] ? 2 : 1)
            ) u_dut (
                .i_clk  (clk),
                .i_rst  (rst),
                .i_data (data),
                .i_valid(valid),
                .o_ready(ready_w[g]),
                .o_tx   (tx_w[g]),
                .o_busy (busy_w[g]),
                .o_done (done_w[g])
            );
        end
    endgenerate

    // Frame-level model: position inside the current frame (-1 = idle),
    // byte being sent, one-entry holding register, done pulse.
    int         m_pos [4];
    logic       m_hf  [4];
    logic [7:0] m_hb  [4];
    logic [7:0] m_fb  [4];
    logic       m_done[4];
    bit         model_on = 1'b0;

    function automatic int frame_len(int k);
        return (9 + (PEN_V[k] ? 1 : 0) + (SB2_V[k] ? 2 : 1)) * CPB;
    endfunction

    function automatic logic exp_tx(int k);
        int b;
        if (m_pos[k] < 0) return 1'b1;
        b = m_pos[k] / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_fb[k][b-1];
        if (PEN_V[k] && b == 9) return (^m_fb[k]) ^ POD_V[k];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_pos[k]  <= -1;
                m_hf[k]   <= 1'b0;
                m_hb[k]   <= 8'h00;
                m_fb[k]   <= 8'h00;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_done[k] <= (m_pos[k] == frame_len(k) - 1);
                if (m_pos[k] >= 0 && m_pos[k] < frame_len(k) - 1) begin
                    m_pos[k] <= m_pos[k] + 1;
                end else if (m_hf[k]) begin
                    m_pos[k] <= 0;
                    m_fb[k]  <= m_hb[k];
                end else begin
                    m_pos[k] <= -1;
                end
                if (valid && !m_hf[k]) begin
                    m_hf[k] <= 1'b1;
                    m_hb[k] <= data;
                end else if (m_hf[k] && (m_pos[k] < 0 || m_pos[k] == frame_len(k) - 1)) begin
                    m_hf[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %b, expected %b", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 4; k++) begin
                chk("tx", k, tx_w[k], exp_tx(k));
                chk("ready", k, ready_w[k], !m_hf[k]);
                chk("busy", k, busy_w[k], m_pos[k] >= 0);
                chk("done", k, done_w[k], m_done[k]);
            end
        end
    end

    logic [3:0] tx_tr   [64];
    logic [3:0] done_tr [64];
    logic [3:0] busy_tr [64];
    logic [3:0] ready_tr[64];

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
        data  = ~b;
    endtask

    task automatic wait_tx_low();
        int t = 0;
        @(negedge clk);
        while (tx_w[0] !== 1'b0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("start_timeout", 0, tx_w[0], 1'b0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(busy_w === 4'h0 && ready_w === 4'hF) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 0, busy_w === 4'h0 && ready_w === 4'hF, 1'b1);
        @(negedge clk);
    endtask

    // Record 64 cycles starting from the first start-bit cycle of inst0;
    // optionally present one byte for one cycle at index inj_at.
    task automatic capture(input int inj_at, input logic [7:0] inj_byte);
        wait_tx_low();
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            tx_tr[c]    = tx_w;
            done_tr[c]  = done_w;
            busy_tr[c]  = busy_w;
            ready_tr[c] = ready_w;
            if (c == inj_at) begin
                valid = 1'b1;
                data  = inj_byte;
            end else if (c == inj_at + 1) begin
                valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [9:0] seq;
        int         dcnt[4];
        int         lowcnt;

        #1 rst = 1'b1;
        model_on = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_tx", k, tx_w[k], 1'b1);
            chk("rst_ready", k, ready_w[k], 1'b1);
            chk("rst_busy", k, busy_w[k], 1'b0);
            chk("rst_done", k, done_w[k], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 0xA5, no parity, one stop bit
        send(8'hA5);
        capture(-1, 8'h00);
        seq = 10'b1101001010;
        for (int i = 0; i < 10; i++) chk("a5_bit", 0, tx_tr[4*i+2][0], seq[i]);
        chk("a5_done39", 0, done_tr[39][0], 1'b0);
        chk("a5_done40", 0, done_tr[40][0], 1'b1);
        chk("a5_done41", 0, done_tr[41][0], 1'b0);
        chk("a5_busy39", 0, busy_tr[39][0], 1'b1);
        chk("a5_busy40", 0, busy_tr[40][0], 1'b0);
        chk("a5_tx40", 0, tx_tr[40][0], 1'b1);
        chk("a5_par_even", 1, tx_tr[38][1], 1'b0);
        wait_idle();

        // 0x03 with even and odd parity
        send(8'h03);
        capture(-1, 8'h00);
        chk("03_par_even", 1, tx_tr[38][1], 1'b0);
        chk("03_par_odd", 2, tx_tr[38][2], 1'b1);
        chk("03_stop", 1, tx_tr[42][1], 1'b1);
        chk("03_busy43", 1, busy_tr[43][1], 1'b1);
        chk("03_done43", 1, done_tr[43][1], 1'b0);
        chk("03_done44", 1, done_tr[44][1], 1'b1);
        chk("03_done44", 2, done_tr[44][2], 1'b1);
        wait_idle();

        // 0x80 with two stop bits
        send(8'h80);
        capture(-1, 8'h00);
        chk("80_bit6", 3, tx_tr[30][3], 1'b0);
        chk("80_bit7", 3, tx_tr[34][3], 1'b1);
        chk("80_stop37", 3, tx_tr[37][3], 1'b1);
        chk("80_stop43", 3, tx_tr[43][3], 1'b1);
        chk("80_busy43", 3, busy_tr[43][3], 1'b1);
        chk("80_done43", 3, done_tr[43][3], 1'b0);
        chk("80_done44", 3, done_tr[44][3], 1'b1);
        chk("80_done40", 0, done_tr[40][0], 1'b1);
        wait_idle();

        // 0x00 then 0xFF accepted mid-frame: back-to-back frames
        send(8'h00);
        capture(10, 8'hFF);
        chk("b2b_data0", 0, tx_tr[22][0], 1'b0);
        chk("b2b_ready10", 0, ready_tr[10][0], 1'b1);
        chk("b2b_ready11", 0, ready_tr[11][0], 1'b0);
        chk("b2b_ready39", 0, ready_tr[39][0], 1'b0);
        chk("b2b_ready40", 0, ready_tr[40][0], 1'b1);
        chk("b2b_stop39", 0, tx_tr[39][0], 1'b1);
        chk("b2b_start40", 0, tx_tr[40][0], 1'b0);
        chk("b2b_start43", 0, tx_tr[43][0], 1'b0);
        chk("b2b_busy40", 0, busy_tr[40][0], 1'b1);
        chk("b2b_done40", 0, done_tr[40][0], 1'b1);
        chk("b2b_ff_bit0", 0, tx_tr[46][0], 1'b1);
        chk("b2b_stop43", 3, tx_tr[43][3], 1'b1);
        chk("b2b_start44", 3, tx_tr[44][3], 1'b0);
        chk("b2b_ready43", 3, ready_tr[43][3], 1'b0);
        chk("b2b_ready44", 3, ready_tr[44][3], 1'b1);
        wait_idle();

        // valid held high with 0x11 while the holding register is full
        send(8'h22);
        repeat (3) @(negedge clk);
        valid = 1'b1;
        data  = 8'h33;
        @(negedge clk);
        data  = 8'h11;
        chk("hold_full", 0, ready_w[0], 1'b0);
        for (int k = 0; k < 4; k++) dcnt[k] = 0;
        for (int c = 0; c < 130; c++) begin
            if (c == 20) valid = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 4; k++) dcnt[k] += (done_w[k] === 1'b1) ? 1 : 0;
        end
        chk_int("frames_per_accept", 0, dcnt[0], 2);
        chk_int("frames_per_accept", 3, dcnt[3], 2);
        wait_idle();

        // reset in the middle of DATA with a byte held
        send(8'h5A);
        wait_tx_low();
        repeat (9) @(negedge clk);
        valid = 1'b1;
        data  = 8'hC3;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_held", 0, ready_w[0], 1'b0);
        chk("pre_rst_busy", 0, busy_w[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("arst_tx", k, tx_w[k], 1'b1);
            chk("arst_ready", k, ready_w[k], 1'b1);
            chk("arst_busy", k, busy_w[k], 1'b0);
            chk("arst_done", k, done_w[k], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        dcnt[0] = 0;
        lowcnt  = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            dcnt[0] += (done_w[0] === 1'b1) ? 1 : 0;
            lowcnt  += (tx_w[0] !== 1'b1) ? 1 : 0;
        end
        chk_int("post_rst_done", 0, dcnt[0], 0);
        chk_int("post_rst_tx_low", 0, lowcnt, 0);

        // first accept after reset behaves as from power-up
        send(8'h3C);
        capture(-1, 8'h00);
        seq = 10'b1001111000;
        for (int i = 0; i < 10; i++) chk("3c_bit", 0, tx_tr[4*i+2][0], seq[i]);
        chk("3c_done40", 0, done_tr[40][0], 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
